// File: rtl/coop_comm_pkg.sv
// Shared definitions for the co-op UART link framers (rx and tx sides).
package coop_comm_pkg;

   localparam logic [7:0] START_BYTE = 8'hAA;
   localparam int         X_W        = 10;

   typedef enum logic [1:0] {
      RX_HUNT      = 2'd0,
      RX_GOT_START = 2'd1,
      RX_GOT_XL    = 2'd2
   } rx_state_e;

endpackage

// File: rtl/coop_comm_rx_if.sv
// Byte stream from the UART rx core into the framer, and the framer's results to game logic.
interface coop_comm_rx_if;
   import coop_comm_pkg::*;

   logic [7:0]     rx_data;
   logic           rx_done;
   logic [X_W+1:0] remote_x;
   logic           remote_valid;
   logic           link_up;
   logic [7:0]     frame_err;

   modport master (
      output rx_data, rx_done,
      input  remote_x, remote_valid, link_up, frame_err
   );

   modport slave (
      input  rx_data, rx_done,
      output remote_x, remote_valid, link_up, frame_err
   );

endinterface

// File: rtl/coop_link_timer.sv
// Saturating up-counter with synchronous clear; o_expired holds while the count sits at MAX_COUNT-1.
module coop_link_timer #(
   parameter int MAX_COUNT = 20_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int              CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

   logic [CNT_W-1:0] r_count;

   // Clear has priority so a fresh event restarts the window even when already expired.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired = (r_count == LAST);

endmodule

// File: rtl/coop_comm_rx.sv
// Receive framer: parses {0xAA, X[7:0], {6'b0,X[9:8]}} frames into remote X, link-alive and error count.
module coop_comm_rx
   import coop_comm_pkg::*;
#(
   parameter int BYTE_TIMEOUT = 20_000,
   parameter int LINK_TIMEOUT = 6_500_000
) (
   input  logic           clk,
   input  logic           rst_n,
   coop_comm_rx_if.slave  rx_if
);

   rx_state_e      r_state;
   rx_state_e      w_nextState;
   logic [7:0]     r_xl;
   logic [X_W+1:0] r_remoteX;
   logic           r_remoteValid;
   logic           r_linkUp;
   logic [7:0]     r_frameErr;
   logic           w_accept;
   logic           w_errInc;
   logic           w_byteExpired;
   logic           w_linkExpired;

   coop_link_timer #(.MAX_COUNT(BYTE_TIMEOUT)) u_byteTimer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (rx_if.rx_done),
      .i_enable  (r_state != RX_HUNT),
      .o_expired (w_byteExpired)
   );

   coop_link_timer #(.MAX_COUNT(LINK_TIMEOUT)) u_linkTimer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_accept),
      .i_enable  (1'b1),
      .o_expired (w_linkExpired)
   );

   // An arriving byte always takes precedence over a byte timeout in the same cycle.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_errInc    = 1'b0;
      case (r_state)
         RX_HUNT: begin
            if (rx_if.rx_done && (rx_if.rx_data == START_BYTE)) begin
               w_nextState = RX_GOT_START;
            end
         end
         RX_GOT_START: begin
            if (rx_if.rx_done) begin
               w_nextState = RX_GOT_XL;
            end else if (w_byteExpired) begin
               w_nextState = RX_HUNT;
               w_errInc    = 1'b1;
            end
         end
         RX_GOT_XL: begin
            if (rx_if.rx_done) begin
               if (rx_if.rx_data[7:2] == 6'd0) begin
                  w_accept    = 1'b1;
                  w_nextState = RX_HUNT;
               end else begin
                  w_errInc    = 1'b1;
                  w_nextState = (rx_if.rx_data == START_BYTE) ? RX_GOT_START : RX_HUNT;
               end
            end else if (w_byteExpired) begin
               w_nextState = RX_HUNT;
               w_errInc    = 1'b1;
            end
         end
         default: w_nextState = RX_HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= RX_HUNT;
         r_xl          <= '0;
         r_remoteX     <= '0;
         r_remoteValid <= 1'b0;
         r_linkUp      <= 1'b0;
         r_frameErr    <= '0;
      end else begin
         r_state       <= w_nextState;
         r_remoteValid <= w_accept;
         if ((r_state == RX_GOT_START) && rx_if.rx_done) begin
            r_xl <= rx_if.rx_data;
         end
         if (w_accept) begin
            r_remoteX <= {2'b00, rx_if.rx_data[1:0], r_xl};
         end
         if (w_accept) begin
            r_linkUp <= 1'b1;
         end else if (w_linkExpired) begin
            r_linkUp <= 1'b0;
         end
         if (w_errInc && (r_frameErr != 8'hFF)) begin
            r_frameErr <= r_frameErr + 8'd1;
         end
      end
   end

   assign rx_if.remote_x     = r_remoteX;
   assign rx_if.remote_valid = r_remoteValid;
   assign rx_if.link_up      = r_linkUp;
   assign rx_if.frame_err    = r_frameErr;

endmodule

// File: tb/tb_coop_comm_rx.sv
// Self-checking bench for coop_comm_rx: fixed frame vectors, timeout corners and a randomized byte stream.
module tb_coop_comm_rx;
   import coop_comm_pkg::*;

   localparam int BYTE_TO = 50;
   localparam int LINK_TO = 200;

   logic clk = 1'b0;
   logic rst_n;

   coop_comm_rx_if bus();

   coop_comm_rx #(
      .BYTE_TIMEOUT (BYTE_TO),
      .LINK_TIMEOUT (LINK_TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_if (bus)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: a frame is the list of bytes collected so far; timing is cycle arithmetic.
   logic [7:0]  frameQ[$];
   int          cyc      = 0;
   int          lastByte = 0;
   int          lastGood = 0;
   bit          hasGood  = 0;
   logic [11:0] mX       = '0;
   bit          mValid   = 0;
   bit          mLink    = 0;
   int          mErr     = 0;

   typedef struct {
      int          gap;
      logic [7:0]  data;
      logic [11:0] expX;
      logic        expValid;
      logic        expLink;
      logic [7:0]  expErr;
   } vec_t;

   vec_t vecs[15];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic bumpErr();
      if (mErr < 255) mErr++;
      frameQ.delete();
   endtask

   task automatic modelStep(input bit rstn, input bit done, input logic [7:0] d);
      mValid = 0;
      if (!rstn) begin
         frameQ.delete();
         hasGood = 0;
         mX      = '0;
         mErr    = 0;
      end else if (done) begin
         lastByte = cyc;
         if (frameQ.size() == 0) begin
            if (d == START_BYTE) frameQ.push_back(d);
         end else if (frameQ.size() == 1) begin
            frameQ.push_back(d);
         end else if (d[7:2] == 6'd0) begin
            mX       = {2'b00, d[1:0], frameQ[1]};
            mValid   = 1;
            hasGood  = 1;
            lastGood = cyc;
            frameQ.delete();
         end else begin
            bumpErr();
            if (d == START_BYTE) frameQ.push_back(d);
         end
      end else if ((frameQ.size() != 0) && (cyc - lastByte == BYTE_TO)) begin
         bumpErr();
      end
      mLink = hasGood && ((cyc - lastGood) < LINK_TO);
      cyc++;
   endtask

   task automatic applyStimulus(input bit rstn, input bit done, input logic [7:0] data);
      rst_n       = rstn;
      bus.rx_done = done;
      bus.rx_data = data;
      @(posedge clk);
      modelStep(rstn, done, data);
      #1;
      checkOutput($sformatf("cyc%0d.remote_x", cyc), 32'(bus.remote_x), 32'(mX));
      checkOutput($sformatf("cyc%0d.remote_valid", cyc), 32'(bus.remote_valid), 32'(mValid));
      checkOutput($sformatf("cyc%0d.link_up", cyc), 32'(bus.link_up), 32'(mLink));
      checkOutput($sformatf("cyc%0d.frame_err", cyc), 32'(bus.frame_err), 32'(mErr));
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b1, 1'b0, 8'($urandom));
   endtask

   task automatic sendByte(input int gap, input logic [7:0] data);
      idle(gap);
      applyStimulus(1'b1, 1'b1, data);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic expectAll(input string tag, input logic [11:0] x, input logic v,
                            input logic l, input logic [7:0] e);
      checkOutput({tag, ".remote_x"}, 32'(bus.remote_x), 32'(x));
      checkOutput({tag, ".remote_valid"}, 32'(bus.remote_valid), 32'(v));
      checkOutput({tag, ".link_up"}, 32'(bus.link_up), 32'(l));
      checkOutput({tag, ".frame_err"}, 32'(bus.frame_err), 32'(e));
   endtask

   task automatic randomPhase();
      logic [7:0] d;
      int         g;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) doReset();
         if ($urandom_range(0, 9) == 0)       g = int'($urandom_range(45, 60));
         else if ($urandom_range(0, 29) == 0) g = int'($urandom_range(190, 215));
         else                                 g = int'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       d = START_BYTE;
            1:       d = 8'($urandom_range(0, 3));
            2:       d = 8'($urandom_range(0, 7));
            default: d = 8'($urandom);
         endcase
         sendByte(g, d);
      end
   endtask

   initial begin
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      doReset();
      expectAll("reset", 12'h000, 1'b0, 1'b0, 8'd0);

      vecs[0]  = '{16, 8'hAA, 12'h000, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{16, 8'h34, 12'h000, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{16, 8'h02, 12'h234, 1'b1, 1'b1, 8'd0};
      vecs[3]  = '{ 2, 8'h55, 12'h234, 1'b0, 1'b1, 8'd0};
      vecs[4]  = '{ 2, 8'hAA, 12'h234, 1'b0, 1'b1, 8'd0};
      vecs[5]  = '{ 2, 8'hAA, 12'h234, 1'b0, 1'b1, 8'd0};
      vecs[6]  = '{ 2, 8'h03, 12'h3AA, 1'b1, 1'b1, 8'd0};
      vecs[7]  = '{ 2, 8'hAA, 12'h3AA, 1'b0, 1'b1, 8'd0};
      vecs[8]  = '{ 2, 8'h10, 12'h3AA, 1'b0, 1'b1, 8'd0};
      vecs[9]  = '{ 2, 8'hFF, 12'h3AA, 1'b0, 1'b1, 8'd1};
      vecs[10] = '{ 2, 8'hAA, 12'h3AA, 1'b0, 1'b1, 8'd1};
      vecs[11] = '{ 2, 8'hAA, 12'h3AA, 1'b0, 1'b1, 8'd1};
      vecs[12] = '{ 2, 8'hAA, 12'h3AA, 1'b0, 1'b1, 8'd2};
      vecs[13] = '{ 2, 8'hAA, 12'h3AA, 1'b0, 1'b1, 8'd2};
      vecs[14] = '{ 2, 8'h01, 12'h1AA, 1'b1, 1'b1, 8'd2};
      for (int i = 0; i < 15; i++) begin
         sendByte(vecs[i].gap, vecs[i].data);
         expectAll($sformatf("vec%0d", i), vecs[i].expX, vecs[i].expValid,
                   vecs[i].expLink, vecs[i].expErr);
      end
      idle(1);
      expectAll("validDrop", 12'h1AA, 1'b0, 1'b1, 8'd2);

      // Second byte well after the timeout: stale bytes are dropped, the next frame is fine.
      doReset();
      sendByte(1, 8'hAA);
      idle(60);
      sendByte(0, 8'h05);
      sendByte(0, 8'h01);
      expectAll("toLate", 12'h000, 1'b0, 1'b0, 8'd1);
      sendByte(2, 8'hAA);
      sendByte(2, 8'h07);
      sendByte(2, 8'h03);
      expectAll("toRecover", 12'h307, 1'b1, 1'b1, 8'd1);

      // Bytes landing exactly in the expiry cycle win; one cycle later they do not.
      doReset();
      sendByte(1, 8'hAA);
      sendByte(BYTE_TO - 1, 8'h55);
      sendByte(BYTE_TO - 1, 8'h01);
      expectAll("toExact", 12'h155, 1'b1, 1'b1, 8'd0);
      sendByte(1, 8'hAA);
      sendByte(BYTE_TO, 8'h11);
      expectAll("toPastOne", 12'h155, 1'b0, 1'b1, 8'd1);

      sendByte(2, 8'hAA);
      sendByte(2, 8'h2C);
      sendByte(2, 8'h01);
      expectAll("linkFrame", 12'h12C, 1'b1, 1'b1, 8'd1);
      idle(LINK_TO - 1);
      expectAll("linkHold", 12'h12C, 1'b0, 1'b1, 8'd1);
      idle(1);
      expectAll("linkDrop", 12'h12C, 1'b0, 1'b0, 8'd1);

      sendByte(2, 8'hAA);
      sendByte(2, 8'h12);
      doReset();
      expectAll("midReset", 12'h000, 1'b0, 1'b0, 8'd0);
      sendByte(2, 8'h01);
      expectAll("afterReset", 12'h000, 1'b0, 1'b0, 8'd0);

      randomPhase();

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
